bram_stream_reader: RTL

//  Read-side counterpart to the BRAM writer. On a start command, reads i_len consecutive

---
 rtl/bram_stream_reader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Generic register FIFO: holds up to DEPTH entries, head visible combinationally from storage.
// Latency: a write is visible at the head in the cycle after it is written.
// Backpressure: pops only when rd_rdy and non-empty; the writer must never push into a full FIFO.
module bram_stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_rdy && rd_vld;

    // Storage array; contents need no reset because rd_vld gates their use.
    always_ff @(posedge i_clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(wr_vld) - CW'(pop);
        end
    end

    // Credit accounting upstream must make a push into a full FIFO impossible.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(wr_vld && (count == CW'(DEPTH))));
        end
    end
endmodule

// Streams i_len consecutive BRAM words from i_base_addr as a valid/ready stream with last flag.
// Latency: first o_bram_en one cycle after start; first o_valid READ_LATENCY+2 cycles after start.
// Backpressure: reads issue only against free FIFO credits, so a stalled sink pauses reads losslessly.
module bram_stream_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_bram_en,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready
);
    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int LW         = ADDR_WIDTH + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           issued;
    logic [LW-1:0]           received;
    logic [READ_LATENCY-1:0] pipe;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             outstanding;
    logic                    issue;
    logic                    mature;
    logic                    wr_last;
    logic                    pop;
    logic                    head_vld;
    logic [DATA_WIDTH:0]     head_dat;

    // Count reads still travelling through the BRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

    // Every in-flight read plus every buffered word holds one FIFO credit.
    assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue       = (state == READ) && (outstanding < CREDITS);
    assign mature      = pipe[READ_LATENCY-1];
    assign wr_last     = ((received + LW'(1)) == len_q);

    assign o_bram_en   = issue;
    assign o_bram_addr = issue ? cur_addr : last_addr;

    assign o_valid = head_vld;
    assign o_data  = head_vld ? head_dat[DATA_WIDTH-1:0] : '0;
    assign o_last  = head_vld && head_dat[DATA_WIDTH];
    assign pop     = head_vld && i_ready;

    bram_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .wr_vld (mature),
        .wr_dat ({wr_last, i_bram_dout}),
        .rd_rdy (i_ready),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .count  (fifo_count)
    );

    // Transfer FSM with read-pipe tracking, address generation and registered busy/done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            cur_addr  <= '0;
            last_addr <= '0;
            len_q     <= '0;
            issued    <= '0;
            received  <= '0;
            pipe      <= '0;
        end else begin
            o_done <= 1'b0;
            pipe   <= (pipe << 1) | READ_LATENCY'(issue);
            if (mature) begin
                received <= received + LW'(1);
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cur_addr <= i_base_addr;
                        len_q    <= i_len;
                        issued   <= '0;
                        received <= '0;
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state  <= READ;
                            o_busy <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        last_addr <= cur_addr;
                        issued    <= issued + LW'(1);
                        if ((issued + LW'(1)) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last beat leaving the FIFO implies no reads remain in flight.
                    if (pop && o_last) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
